// File: rtl/cmp_mask_acc_pkg.sv
// Shared vector ALU types: comparator predicate encoding and mask-accumulator FSM states.
// Predicate helpers keep the LEQ/result-select decoding in one place.
package cmp_mask_acc_pkg;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_LE = 2'd1,
    CMP_GT = 2'd2,
    CMP_GE = 2'd3
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_MASK_WIDTH = 32;

  // LE and GT share the comparator's "or equal" path (GT == !LE).
  function automatic logic uses_leq(input cmp_op_e op);
    return (op == CMP_LE) || (op == CMP_GT);
  endfunction

  function automatic logic uses_lt_le(input cmp_op_e op);
    return (op == CMP_LT) || (op == CMP_LE);
  endfunction

endpackage

// File: rtl/cmp_mask_acc_if.sv
// Instruction, comparator and mask-result signals of the compare mask accumulator.
// slave = accumulator view, master = issue/comparator/consumer view.
interface cmp_mask_acc_if #(
  parameter int MASK_WIDTH = 32,
  parameter int CNT_W      = $clog2(MASK_WIDTH) + 1
);
  logic                  start_i;
  logic [1:0]            op_i;
  logic [CNT_W-1:0]      vl_i;
  logic                  vm_i;
  logic [MASK_WIDTH-1:0] v0_i;
  logic [MASK_WIDTH-1:0] old_mask_i;
  logic                  leq_o;
  logic                  cmp_en_o;
  logic                  cmp_valid_i;
  logic                  lt_le_i;
  logic                  ge_gt_i;
  logic                  busy_o;
  logic [MASK_WIDTH-1:0] mask_o;
  logic                  mask_valid_o;
  logic                  mask_ready_i;

  modport slave (
    input  start_i, op_i, vl_i, vm_i, v0_i, old_mask_i,
    input  cmp_valid_i, lt_le_i, ge_gt_i, mask_ready_i,
    output leq_o, cmp_en_o, busy_o, mask_o, mask_valid_o
  );

  modport master (
    output start_i, op_i, vl_i, vm_i, v0_i, old_mask_i,
    output cmp_valid_i, lt_le_i, ge_gt_i, mask_ready_i,
    input  leq_o, cmp_en_o, busy_o, mask_o, mask_valid_o
  );
endinterface

// File: rtl/cmp_mask_acc.sv
// Builds a vector compare mask one element per comparator result; mask_valid rises 1 cycle after the last result.
// Result is held in DONE until mask_ready; comparator results stall freely (no cmp_valid = hold).
module cmp_mask_acc
  import cmp_mask_acc_pkg::*;
#(
  parameter int MASK_WIDTH = DEFAULT_MASK_WIDTH,
  parameter int CNT_W      = $clog2(MASK_WIDTH) + 1
) (
  input logic          module_clk_i,
  input logic          rst_ni,
  cmp_mask_acc_if.slave bus
);

  localparam int IDX_W = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1;

  state_e                state, state_nxt;
  cmp_op_e               op_q;
  logic [CNT_W-1:0]      vl_q;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      vl_clamped;
  logic                  vm_q;
  logic [MASK_WIDTH-1:0] v0_q;
  logic [MASK_WIDTH-1:0] acc;
  logic [IDX_W-1:0]      idx;
  logic                  launch;
  logic                  take;
  logic                  elem_active;
  logic                  elem_bit;
  logic                  last;

  always_comb begin
    vl_clamped  = (bus.vl_i > CNT_W'(MASK_WIDTH)) ? CNT_W'(MASK_WIDTH) : bus.vl_i;
    idx         = cnt[IDX_W-1:0];
    launch      = (state == ST_IDLE) && bus.start_i;
    take        = (state == ST_RUN) && bus.cmp_valid_i;
    elem_active = vm_q || v0_q[idx];
    elem_bit    = uses_lt_le(op_q) ? bus.lt_le_i : bus.ge_gt_i;
    last        = (cnt + CNT_W'(1)) == vl_q;
  end

  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.cmp_en_o     = 1'b0;
    bus.busy_o       = 1'b0;
    bus.mask_valid_o = 1'b0;
    bus.leq_o        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_nxt = (vl_clamped == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        bus.cmp_en_o = 1'b1;
        bus.busy_o   = 1'b1;
        bus.leq_o    = uses_leq(op_q);
        if (take && last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.busy_o       = 1'b1;
        bus.mask_valid_o = 1'b1;
        // start_i in this cycle is deliberately dropped; IDLE samples it next cycle
        if (bus.mask_ready_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // acc starts as old_mask, so masked-off and tail bits are never touched
  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q <= CMP_LT;
      vl_q <= '0;
      vm_q <= 1'b0;
      v0_q <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (launch) begin
      op_q <= cmp_op_e'(bus.op_i);
      vl_q <= vl_clamped;
      vm_q <= bus.vm_i;
      v0_q <= bus.v0_i;
      acc  <= bus.old_mask_i;
      cnt  <= '0;
    end else if (take) begin
      if (elem_active) begin
        acc[idx] <= elem_bit;
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.mask_o = acc;

endmodule

// File: tb/tb_cmp_mask_acc.sv
// Directed bench for cmp_mask_acc: hand-computed masks, handshake hold, clamp and mid-run reset.
module tb_cmp_mask_acc;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cmp_mask_acc_if bus ();

  cmp_mask_acc dut (
    .module_clk_i(clk),
    .rst_ni      (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    bus.mask_ready_i = 1'b1;
    tick();
    bus.mask_ready_i = 1'b0;
  endtask

  initial begin
    logic [3:0] pat4;
    logic [2:0] pat3;

    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.op_i         = 2'd0;
    bus.vl_i         = '0;
    bus.vm_i         = 1'b1;
    bus.v0_i         = '0;
    bus.old_mask_i   = '0;
    bus.cmp_valid_i  = 1'b0;
    bus.lt_le_i      = 1'b0;
    bus.ge_gt_i      = 1'b0;
    bus.mask_ready_i = 1'b0;
    repeat (2) tick();

    chk("rst_mask", bus.mask_o, 32'h0);
    chk("rst_valid", 32'(bus.mask_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_cmp_en", 32'(bus.cmp_en_o), 32'd0);
    chk("rst_leq", 32'(bus.leq_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // results arriving while idle must not disturb anything
    bus.cmp_valid_i = 1'b1;
    bus.lt_le_i     = 1'b1;
    tick();
    bus.cmp_valid_i = 1'b0;
    chk("idle_ignore_busy", 32'(bus.busy_o), 32'd0);
    chk("idle_ignore_mask", bus.mask_o, 32'h0);

    // LT, vl=4, unmasked, old=FFFFFFF0, lt_le=1,0,1,1 with one stall cycle
    bus.op_i = 2'd0; bus.vl_i = 6'd4; bus.vm_i = 1'b1; bus.old_mask_i = 32'hFFFF_FFF0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("lt_busy", 32'(bus.busy_o), 32'd1);
    chk("lt_cmp_en", 32'(bus.cmp_en_o), 32'd1);
    chk("lt_leq", 32'(bus.leq_o), 32'd0);
    pat4 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.cmp_valid_i = 1'b0;
        bus.lt_le_i     = 1'b0;
        tick();
      end
      bus.cmp_valid_i = 1'b1;
      bus.lt_le_i     = pat4[i];
      bus.ge_gt_i     = ~pat4[i];
      tick();
      if (i == 2) chk("lt_valid_early", 32'(bus.mask_valid_o), 32'd0);
    end
    bus.cmp_valid_i = 1'b0;
    chk("lt_valid", 32'(bus.mask_valid_o), 32'd1);
    chk("lt_mask", bus.mask_o, 32'hFFFF_FFFD);
    chk("lt_done_cmp_en", 32'(bus.cmp_en_o), 32'd0);
    chk("lt_done_busy", 32'(bus.busy_o), 32'd1);
    handshake();
    chk("lt_hs_valid", 32'(bus.mask_valid_o), 32'd0);
    chk("lt_hs_busy", 32'(bus.busy_o), 32'd0);

    // GE, vl=3, vm=0, v0=101, old=010, ge_gt=0,1,0
    bus.op_i = 2'd3; bus.vl_i = 6'd3; bus.vm_i = 1'b0; bus.v0_i = 32'b101; bus.old_mask_i = 32'b010;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("ge_leq", 32'(bus.leq_o), 32'd0);
    pat3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      bus.cmp_valid_i = 1'b1;
      bus.ge_gt_i     = pat3[i];
      bus.lt_le_i     = ~pat3[i];
      tick();
    end
    bus.cmp_valid_i = 1'b0;
    chk("ge_valid", 32'(bus.mask_valid_o), 32'd1);
    chk("ge_mask", bus.mask_o, 32'h0000_0002);
    handshake();

    // same masking, ge_gt=1,0,1: inactive bit1 must keep old 1 despite a 0 result
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    pat3 = 3'b101;
    for (int i = 0; i < 3; i++) begin
      bus.cmp_valid_i = 1'b1;
      bus.ge_gt_i     = pat3[i];
      bus.lt_le_i     = ~pat3[i];
      tick();
    end
    bus.cmp_valid_i = 1'b0;
    chk("ge_undist_mask", bus.mask_o, 32'h0000_0007);
    handshake();

    // vl=0: straight to DONE with old mask, then ready held low with start and results poking
    bus.op_i = 2'd1; bus.vl_i = 6'd0; bus.vm_i = 1'b1; bus.old_mask_i = 32'hA5A5_A5A5;
    bus.start_i = 1'b1;
    tick();
    chk("vl0_valid", 32'(bus.mask_valid_o), 32'd1);
    chk("vl0_mask", bus.mask_o, 32'hA5A5_A5A5);
    chk("vl0_cmp_en", 32'(bus.cmp_en_o), 32'd0);
    chk("vl0_leq", 32'(bus.leq_o), 32'd0);
    bus.vl_i = 6'd5; bus.old_mask_i = 32'h0; bus.cmp_valid_i = 1'b1; bus.lt_le_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_mask", bus.mask_o, 32'hA5A5_A5A5);
      chk("hold_valid", 32'(bus.mask_valid_o), 32'd1);
      chk("hold_cmp_en", 32'(bus.cmp_en_o), 32'd0);
    end
    handshake();
    chk("hs_start_valid", 32'(bus.mask_valid_o), 32'd0);
    chk("hs_start_busy", 32'(bus.busy_o), 32'd0);
    bus.start_i = 1'b0; bus.cmp_valid_i = 1'b0;
    tick();
    chk("hs_start_idle", 32'(bus.busy_o), 32'd0);

    // GT, vl=40 clamps to 32, ge_gt alternates 0,1,...
    bus.op_i = 2'd2; bus.vl_i = 6'd40; bus.vm_i = 1'b1; bus.old_mask_i = 32'h0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("gt_leq", 32'(bus.leq_o), 32'd1);
    for (int i = 0; i < 32; i++) begin
      bus.cmp_valid_i = 1'b1;
      bus.ge_gt_i     = i[0];
      bus.lt_le_i     = ~i[0];
      tick();
      if (i == 30) begin
        chk("clamp_valid_early", 32'(bus.mask_valid_o), 32'd0);
        chk("clamp_busy", 32'(bus.busy_o), 32'd1);
      end
    end
    bus.ge_gt_i = 1'b1;
    chk("clamp_valid", 32'(bus.mask_valid_o), 32'd1);
    chk("clamp_mask", bus.mask_o, 32'hAAAA_AAAA);
    tick();
    bus.cmp_valid_i = 1'b0;
    chk("done_ignore_mask", bus.mask_o, 32'hAAAA_AAAA);
    handshake();

    // LE, vl=8, async reset after 2 results
    bus.op_i = 2'd1; bus.vl_i = 6'd8; bus.old_mask_i = 32'hFFFF_0000;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.cmp_valid_i = 1'b1;
      bus.lt_le_i     = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mask", bus.mask_o, 32'h0);
    chk("arst_valid", 32'(bus.mask_valid_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_cmp_en", 32'(bus.cmp_en_o), 32'd0);
    chk("arst_leq", 32'(bus.leq_o), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("arst_no_pulse", 32'(bus.mask_valid_o), 32'd0);
    end
    bus.cmp_valid_i = 1'b0;

    bus.op_i = 2'd1; bus.vl_i = 6'd2; bus.vm_i = 1'b1; bus.old_mask_i = 32'h0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("post_leq", 32'(bus.leq_o), 32'd1);
    for (int i = 0; i < 2; i++) begin
      bus.cmp_valid_i = 1'b1;
      bus.lt_le_i     = 1'b1;
      bus.ge_gt_i     = 1'b0;
      tick();
    end
    bus.cmp_valid_i = 1'b0;
    chk("post_valid", 32'(bus.mask_valid_o), 32'd1);
    chk("post_mask", bus.mask_o, 32'h0000_0003);
    handshake();
    chk("post_hs_busy", 32'(bus.busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_mask_acc.md
CMP_MASK_ACC -- requirements
Module: cmp_mask_acc

Interface
REQ-001 Parameter MASK_WIDTH, default 32, SHALL set the maximum elements per instruction and the mask result width.
REQ-002 Parameter CNT_W, default $clog2(MASK_WIDTH)+1, SHALL set the width of the element counter and vl field.
REQ-003 module_clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start_i  in  1  SHALL request a new instruction; sampled only in IDLE.
REQ-006 op_i  in  2  SHALL select the predicate: 0=LT, 1=LE, 2=GT, 3=GE.
REQ-007 vl_i  in  CNT_W  SHALL give the element count; valid range 0..MASK_WIDTH.
REQ-008 vm_i  in  1  SHALL mean unmasked when 1; when 0, v0_i gates elements.
REQ-009 v0_i  in  MASK_WIDTH  SHALL carry the v0 mask.
REQ-010 old_mask_i  in  MASK_WIDTH  SHALL carry the destination's prior contents.
REQ-011 leq_o  out  1  SHALL drive the comparator LEQ input: 1 for LE/GT, 0 for LT/GE.
REQ-012 cmp_en_o  out  1  SHALL drive the comparator enable; high only in RUN.
REQ-013 cmp_valid_i  in  1  SHALL qualify one comparator result per cycle.
REQ-014 lt_le_i, ge_gt_i  in  1 each  SHALL carry the comparator outputs.
REQ-015 busy_o  out  1  SHALL be high in RUN and DONE.
REQ-016 mask_o  out  MASK_WIDTH  SHALL carry the result.
REQ-017 mask_valid_o  out  1  SHALL qualify mask_o.
REQ-018 mask_ready_i  in  1  SHALL accept mask_o.

Function
REQ-019 States SHALL be IDLE, RUN and DONE.
REQ-020 IDLE->RUN on start_i with vl_i>0; op_i, vl_i, vm_i, v0_i and old_mask_i SHALL be latched, accumulator loaded from old_mask_i, and counter cleared.
REQ-021 IDLE->DONE on start_i with vl_i==0; mask_o SHALL equal old_mask_i unchanged.
REQ-022 vl_i>MASK_WIDTH SHALL be clamped to MASK_WIDTH at latch time.
REQ-023 In RUN, each cmp_valid_i cycle SHALL write element bit[cnt] and increment cnt; cycles without cmp_valid_i SHALL hold state.
REQ-024 Bit value SHALL be lt_le_i for LT/LE and ge_gt_i for GT/GE.
REQ-025 When vm=0 and v0[cnt]=0, bit[cnt] SHALL keep old_mask_i[cnt] (mask-undisturbed), and cnt SHALL still advance.
REQ-026 Bits at index >= vl SHALL keep old_mask_i (tail-undisturbed).
REQ-027 RUN->DONE in the cycle the vl-th result is absorbed; mask_valid_o SHALL rise on the next cycle (1-cycle latency after the last element).
REQ-028 In DONE, mask_valid_o SHALL stay high and mask_o stable until mask_ready_i; the handshake cycle SHALL return the block to IDLE.
REQ-029 cmp_valid_i outside RUN SHALL be ignored.
REQ-030 start_i outside IDLE SHALL be ignored, including start_i coincident with the DONE handshake.
REQ-031 leq_o SHALL be driven combinationally from the latched op in RUN and SHALL be 0 otherwise.

Reset
REQ-032 Reset SHALL force state IDLE, cnt=0, accumulator=0, mask_o=0, mask_valid_o=0, busy_o=0, cmp_en_o=0 and leq_o=0.
REQ-033 Reset asserted mid-RUN or mid-DONE SHALL discard the instruction with no mask_valid_o pulse.

Structure
REQ-034 The cmp_op_e enum (LT, LE, GT, GE) and state_e enum SHALL reside in a shared vector ALU package.
REQ-035 No sub-module is needed; the comparator SHALL remain a separate sibling instance connected via leq_o, cmp_en_o, lt_le_i and ge_gt_i.

Verification
REQ-036 Stimulus: LT, vl=4, vm=1, old_mask=0xFFFFFFF0, lt_le_i=1,0,1,1 -> required: mask_o=0xFFFFFFFD, valid one cycle after the 4th result.
REQ-037 Stimulus: GE, vl=3, vm=0, v0=0b101, old_mask=0b010, ge_gt_i=0,1,0 -> required: mask_o=0b010 (bit1 undisturbed, bits0 and 2 written 0).
REQ-038 Stimulus: start with vl=0, old_mask=0xA5A5A5A5 -> required: DONE next cycle, mask_o=0xA5A5A5A5, cmp_en_o never high.
REQ-039 Stimulus: vl=40, MASK_WIDTH=32 -> required: exactly 32 results consumed, then DONE.
REQ-040 Stimulus: hold mask_ready_i=0 for 5 cycles in DONE -> required: mask_o stable; start_i during that time ignored.
REQ-041 Stimulus: rst_ni asserted after 2 of 8 results -> required: all outputs 0 immediately, no mask_valid_o pulse, next instruction correct.
